// File: rtl/multi_tick_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
package multi_tick_pkg;

   localparam int CNT_W_DEF = 27;

   // Divisors for a 100 MHz board clock.
   localparam int DIV_500HZ = 200000;
   localparam int DIV_1HZ   = 100000000;

   // A divisor of zero has no meaning; treat it as the fastest rate.
   function automatic logic [31:0] clamp_div(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick slice: down-counter with terminal-count reload and a registered pulse.
// With TICK_SQUARE_OUT_EN defined a half-rate square wave output is added.
module tick_channel
   import multi_tick_pkg::*;
#(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DIV_500HZ)
) (
   input  logic             CLK100Mhz,
   input  logic             reset,
   input  logic             en,
   input  logic             restart,
   input  logic             apply,
   input  logic [CNT_W-1:0] new_div,
   output logic             tc,
`ifdef TICK_SQUARE_OUT_EN
   output logic             square_out,
`endif
   output logic             pulse
);

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_DIVC = (RST_DIV == '0) ? ONE : RST_DIV;

   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_nxt;

   // The top only raises apply at a period boundary, while disabled or on restart,
   // so the reload below always uses the divisor that governs the next period.
   assign div_nxt = apply ? new_div : div;
   assign tc      = (cnt == '0);

   always_ff @(posedge CLK100Mhz or negedge reset) begin
      if (!reset) begin
         div   <= RST_DIVC;
         cnt   <= RST_DIVC - ONE;
         pulse <= 1'b0;
      end else begin
         if (apply) begin
            div <= new_div;
         end
         if (restart || !en || tc) begin
            cnt <= div_nxt - ONE;
         end else begin
            cnt <= cnt - ONE;
         end
         pulse <= en && tc && !restart;
      end
   end

`ifdef TICK_SQUARE_OUT_EN
   always_ff @(posedge CLK100Mhz or negedge reset) begin
      if (!reset) begin
         square_out <= 1'b0;
      end else if (restart) begin
         square_out <= 1'b0;
      end else if (en && tc) begin
         square_out <= ~square_out;
      end
   end
`endif

endmodule

// File: rtl/multi_tick_gen.sv
// NUM_CH independent tick generators sharing one pending divisor-load slot.
// Optional square wave outputs are enabled with TICK_SQUARE_OUT_EN.
module multi_tick_gen
   import multi_tick_pkg::*;
#(
   parameter int                      NUM_CH      = 2,
   parameter int                      CNT_W       = CNT_W_DEF,
   parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV = {CNT_W'(DIV_1HZ), CNT_W'(DIV_500HZ)},
   localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK100Mhz,
   input  logic              reset,
   input  logic [NUM_CH-1:0] enable,
   input  logic              sync_restart,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [CH_W-1:0]   load_ch,
   input  logic [CNT_W-1:0]  load_div,
`ifdef TICK_SQUARE_OUT_EN
   output logic [NUM_CH-1:0] square_out,
`endif
   output logic [NUM_CH-1:0] pulse,
   output logic [NUM_CH-1:0] busy
);

   logic [CH_W-1:0]   slot_ch;
   logic [CNT_W-1:0]  slot_div;
   logic [NUM_CH-1:0] tc;
   logic [NUM_CH-1:0] apply;
   logic              accept;
   logic              ch_ok;

   assign accept = load_valid && load_ready;
   assign ch_ok  = (32'(load_ch) < NUM_CH);

   // load_ready doubles as the slot-empty flag; the divisor is clamped on capture.
   always_ff @(posedge CLK100Mhz or negedge reset) begin
      if (!reset) begin
         load_ready <= 1'b1;
         busy       <= '0;
         slot_ch    <= '0;
         slot_div   <= '0;
      end else if (|apply) begin
         load_ready <= 1'b1;
         busy       <= busy & ~apply;
      end else if (accept && ch_ok) begin
         load_ready <= 1'b0;
         slot_ch    <= load_ch;
         slot_div   <= CNT_W'(clamp_div(32'(load_div)));
         busy       <= busy | (NUM_CH'(1) << load_ch);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign apply[c] = !load_ready && (slot_ch == CH_W'(c)) &&
                        (sync_restart || !enable[c] || tc[c]);

      tick_channel #(
         .CNT_W   (CNT_W),
         .RST_DIV (DEFAULT_DIV[c*CNT_W +: CNT_W])
      ) u_ch (
         .CLK100Mhz  (CLK100Mhz),
         .reset      (reset),
         .en         (enable[c]),
         .restart    (sync_restart),
         .apply      (apply[c]),
         .new_div    (slot_div),
         .tc         (tc[c]),
`ifdef TICK_SQUARE_OUT_EN
         .square_out (square_out[c]),
`endif
         .pulse      (pulse[c])
      );
   end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed scoreboard bench for multi_tick_gen with fast divisors {10,4}.
// Square outputs are checked when TICK_SQUARE_OUT_EN is defined.
module tb_multi_tick_gen;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 27;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] enable;
   logic              sync_restart;
   logic              load_valid;
   logic              load_ready;
   logic [0:0]        load_ch;
   logic [CNT_W-1:0]  load_div;
   logic [NUM_CH-1:0] pulse;
   logic [NUM_CH-1:0] busy;
`ifdef TICK_SQUARE_OUT_EN
   logic [NUM_CH-1:0] square_out;
   logic [NUM_CH-1:0] sq_exp = '0;
`endif

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int exp_q[NUM_CH][$];

   multi_tick_gen #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV ({27'd10, 27'd4})
   ) dut (
      .CLK100Mhz    (clk),
      .reset        (reset),
      .enable       (enable),
      .sync_restart (sync_restart),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_ch      (load_ch),
      .load_div     (load_div),
`ifdef TICK_SQUARE_OUT_EN
      .square_out   (square_out),
`endif
      .pulse        (pulse),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance to the drive point (1 time unit after the edge) of cycle t.
   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_series(input int ch, input int first, input int step, input int last);
      for (int t = first; t <= last; t += step) exp_q[ch].push_back(t);
   endtask

   task automatic monitor();
      for (int i = 0; i < NUM_CH; i++) begin
         logic e;
         e = (exp_q[i].size() > 0) && (exp_q[i][0] == cyc);
         chk($sformatf("pulse%0d@%0d", i, cyc), 32'(pulse[i]), 32'(e));
         if (e) begin
            void'(exp_q[i].pop_front());
`ifdef TICK_SQUARE_OUT_EN
            sq_exp[i] = ~sq_exp[i];
            chk($sformatf("square%0d@%0d", i, cyc), 32'(square_out[i]), 32'(sq_exp[i]));
`endif
         end
      end
   endtask

   task automatic chk_hs(input string tag, input logic [1:0] b, input logic r);
      chk({tag, "_busy"}, 32'(busy), 32'(b));
      chk({tag, "_ready"}, 32'(load_ready), 32'(r));
   endtask

   initial begin
      reset        = 1'b0;
      enable       = 2'b11;
      sync_restart = 1'b0;
      load_valid   = 1'b0;
      load_ch      = 1'b0;
      load_div     = '0;

      fork
         forever begin
            @(negedge clk);
            monitor();
         end
      join_none

      // Reset state, then release with both channels enabled.
      @(posedge clk);
      #1;
      chk("rst_pulse", 32'(pulse), 32'd0);
      chk_hs("rst", 2'b00, 1'b1);
      goto(3);
      reset = 1'b1;
      push_series(0, 7, 4, 43);
      push_series(1, 13, 10, 43);
      goto(20);
      chk_hs("run", 2'b00, 1'b1);
      goto(43);
      enable = 2'b00;

      // Mid-period load on ch0, plus a second request stalled behind it.
      goto(45);
      enable = 2'b01;
      exp_q[0].push_back(49);
      exp_q[0].push_back(55);
      push_series(0, 60, 5, 70);
      goto(46);
      load_valid = 1'b1;
      load_ch    = 1'b0;
      load_div   = 27'd6;
      goto(47);
      chk_hs("ld1_pend", 2'b01, 1'b0);
      load_div = 27'd5;
      goto(48);
      chk_hs("ld2_stall", 2'b01, 1'b0);
      goto(49);
      chk_hs("ld1_applied", 2'b00, 1'b1);
      goto(50);
      chk_hs("ld2_accepted", 2'b01, 1'b0);
      load_valid = 1'b0;
      goto(55);
      chk_hs("ld2_applied", 2'b00, 1'b1);
      goto(70);
      enable = 2'b00;

      // Zero divisor to a disabled channel becomes div=1.
      goto(72);
      load_valid = 1'b1;
      load_ch    = 1'b1;
      load_div   = 27'd0;
      goto(73);
      chk_hs("ld0_pend", 2'b10, 1'b0);
      load_valid = 1'b0;
      goto(74);
      chk_hs("ld0_applied", 2'b00, 1'b1);
      enable = 2'b10;
      push_series(1, 75, 1, 84);
      goto(84);
      enable = 2'b00;

      // Restart coinciding with ch0 terminal count realigns both div=5 channels.
      goto(86);
      load_valid = 1'b1;
      load_ch    = 1'b1;
      load_div   = 27'd5;
      goto(87);
      load_valid = 1'b0;
      goto(90);
      enable = 2'b01;
      exp_q[0].push_back(95);
      exp_q[1].push_back(97);
      push_series(0, 105, 5, 110);
      push_series(1, 105, 5, 110);
      goto(92);
      enable = 2'b11;
      goto(98);
      load_valid = 1'b1;
      goto(99);
      chk_hs("rs_pend", 2'b10, 1'b0);
      load_valid   = 1'b0;
      sync_restart = 1'b1;
      goto(100);
      sync_restart = 1'b0;
`ifdef TICK_SQUARE_OUT_EN
      sq_exp = '0;
      chk("rs_square", 32'(square_out), 32'd0);
`endif
      chk_hs("rs_applied", 2'b00, 1'b1);
      goto(110);
      enable = 2'b00;

      // Asynchronous reset during a tick with a load pending.
      goto(112);
      enable = 2'b11;
      goto(116);
      load_valid = 1'b1;
      load_ch    = 1'b0;
      load_div   = 27'd7;
      goto(117);
      load_valid = 1'b0;
      chk("pre_rst_pulse", 32'(pulse), 32'd3);
      chk_hs("pre_rst", 2'b01, 1'b0);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_pulse", 32'(pulse), 32'd0);
      chk_hs("arst", 2'b00, 1'b1);
`ifdef TICK_SQUARE_OUT_EN
      sq_exp = '0;
      chk("arst_square", 32'(square_out), 32'd0);
`endif
      goto(119);
      reset = 1'b1;
      push_series(0, 123, 4, 139);
      push_series(1, 129, 10, 139);
      goto(139);
      enable = 2'b00;

      goto(145);
      chk("q0_empty", 32'(exp_q[0].size()), 32'd0);
      chk("q1_empty", 32'(exp_q[1].size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
